// File: rtl/str_collect_if.sv
// Character-stream collector bus: the strobed byte input and the published line
// outputs. The master modport is the character source / line consumer side, and
// the slave modport is the collector.
interface str_collect_if #(
   parameter int NCHAR = 7
);
   logic                 rdy;        // byte strobe, taken on its rising edge
   logic [7:0]           dIn;        // byte, valid in the cycle rdy rises
   logic [8*NCHAR-1:0]   bOut;       // last completed line, char k at [8k+7:8k]
   logic [3:0]           len;        // characters in bOut
   logic                 lineValid;  // one-cycle pulse, bOut/len just updated
   logic                 ovf;        // one-cycle pulse, overlong line discarded
   logic                 busy;       // a line is partly received

   modport master (
      output rdy, dIn,
      input  bOut, len, lineValid, ovf, busy
   );

   modport slave (
      input  rdy, dIn,
      output bOut, len, lineValid, ovf, busy
   );
endinterface

// File: rtl/str_collect.sv
// Line collector for a strobed character stream. Each rising edge of rdy takes
// one byte from dIn. Bytes are gathered into a capture buffer until the terminator
// arrives. The whole line is then published in parallel with its length and a
// one-cycle lineValid pulse. A line longer than NCHAR is dropped, and ovf pulses
// once when its terminator arrives.
module str_collect #(
   parameter int         NCHAR = 7,      // 1..15
   parameter logic [7:0] TERM  = 8'h0d
) (
   input  logic          clk,
   input  logic          rst,
   str_collect_if.slave  bus
);

   localparam int         W       = 8 * NCHAR;
   localparam logic [3:0] NCHAR_L = 4'(NCHAR);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DROP    = 2'd2
   } state_t;

   state_t         state_q;
   logic [3:0]     count_q;
   logic [W-1:0]   buf_q;
   logic [W-1:0]   bout_q;
   logic [3:0]     len_q;
   logic           line_valid_q;
   logic           ovf_q;
   logic           rdy_d_q;

   logic           take;
   logic           is_term;
   logic           full;
   logic [W-1:0]   buf_ins_d;   // capture buffer with dIn written into slot count
   logic [W-1:0]   pub_d;       // capture buffer with slots >= count forced to zero

   // Strobe qualification and the two candidate buffer images for this cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      take      = bus.rdy & ~rdy_d_q;
      is_term   = (bus.dIn == TERM);
      full      = (count_q == NCHAR_L);
      buf_ins_d = buf_q;
      pub_d     = '0;
      for (int k = 0; k < NCHAR; k++) begin
         if (4'(k) == count_q) begin
            buf_ins_d[8*k +: 8] = bus.dIn;
         end
         if (4'(k) < count_q) begin
            pub_d[8*k +: 8] = buf_q[8*k +: 8];
         end
      end
   end

   // Delayed copy of rdy for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_d_q <= 1'b0;
      end else begin
         // NOTE: sequential state is written with non-blocking assignments so every register samples the values from before the clock edge.
         rdy_d_q <= bus.rdy;
      end
   end

   // Line-assembly FSM with registered publish/overflow outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         // NOTE: the capture buffer is cleared on reset so a line cut off by reset cannot leak into the next line.
         buf_q        <= '0;
         bout_q       <= '0;
         len_q        <= '0;
         line_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         line_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
         case (state_q)
            IDLE: begin
               if (take) begin
                  if (is_term) begin
                     // An empty line. count is 0, so pub_d is all zero.
                     bout_q       <= pub_d;
                     len_q        <= count_q;
                     line_valid_q <= 1'b1;
                     buf_q        <= '0;
                  end else begin
                     buf_q   <= buf_ins_d;
                     count_q <= 4'd1;
                     state_q <= COLLECT;
                  end
               end
            end

            COLLECT: begin
               if (take) begin
                  if (is_term) begin
                     bout_q       <= pub_d;
                     len_q        <= count_q;
                     line_valid_q <= 1'b1;
                     buf_q        <= '0;
                     count_q      <= '0;
                     state_q      <= IDLE;
                  end else if (!full) begin
                     buf_q   <= buf_ins_d;
                     count_q <= count_q + 4'd1;
                  end else begin
                     // One byte too many: discard the rest of this line.
                     state_q <= DROP;
                  end
               end
            end

            DROP: begin
               if (take && is_term) begin
                  ovf_q   <= 1'b1;
                  buf_q   <= '0;
                  count_q <= '0;
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
               count_q <= '0;
               buf_q   <= '0;
            end
         endcase
      end
   end

   assign bus.bOut      = bout_q;
   assign bus.len       = len_q;
   assign bus.lineValid = line_valid_q;
   assign bus.ovf       = ovf_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
